digit_counter_bank: RTL and testbench

Parametrised bank of DIGITS independent 4-bit digit counters, each stepped by its own debounced switch/button input.
Successor to the raw-edge nibble incrementer: fully synchronous to one clock, glitch-free, with up/down, hex/BCD mode, synchronous clear and a change strobe.
Drives the 7-segment scan/P2S display path with num.

---
 rtl/digit_counter_bank.sv | 115 +++++++++++
 tb/tb_digit_counter_bank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/digit_counter_bank.sv
// digit_counter_bank: DIGITS independent 4-bit digit counters, each stepped by
// a synchronised and debounced switch input. Hex/BCD, up/down, synchronous
// clear, and a registered change strobe.
module digit_counter_bank #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned DEB_CYCLES = 16,
    parameter logic [4*DIGITS-1:0] INIT = (4*DIGITS)'(16'h5703)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     sw,
    input  logic                  dir,
    input  logic                  bcd,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   num,
    output logic                  changed
);

    localparam int unsigned NW = 4 * DIGITS;
    localparam int unsigned CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [DIGITS-1:0] step;
    logic [NW-1:0]     num_next;
    logic              any_step;
    logic              upd;

    // Next value of one digit for a single step in the selected mode.
    function automatic logic [3:0] step_digit(input logic [3:0] d,
                                              input logic       down,
                                              input logic       dec);
        logic [3:0] r;
        if (dec) begin
            if (d > 4'd9)
                r = down ? 4'd9 : 4'd0;
            else if (down)
                r = (d == 4'd0) ? 4'd9 : d - 4'd1;
            else
                r = (d == 4'd9) ? 4'd0 : d + 4'd1;
        end else begin
            r = down ? d - 4'd1 : d + 4'd1;
        end
        return r;
    endfunction

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_chan
            logic          s1;
            logic          s2;
            logic          st;
            logic          st_prev;
            logic          step_q;
            logic [CW-1:0] cnt;

            // Synchronise, debounce, and register a pulse on each accepted rising level.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1      <= 1'b0;
                    s2      <= 1'b0;
                    st      <= 1'b0;
                    st_prev <= 1'b0;
                    step_q  <= 1'b0;
                    cnt     <= '0;
                end else begin
                    s1      <= sw[g];
                    s2      <= s1;
                    st_prev <= st;
                    step_q  <= st & ~st_prev;
                    if (s2 == st) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        st  <= s2;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end

            assign step[g] = step_q;
        end
    endgenerate

    // Apply every pending step to its own digit; no carries between digits.
    always_comb begin
        num_next = num;
        any_step = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (step[i]) begin
                num_next[4*i +: 4] = step_digit(num[4*i +: 4], dir, bcd);
                any_step = 1'b1;
            end
        end
    end

    // Digit register; clear wins over steps and suppresses the change strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num     <= INIT;
            upd     <= 1'b0;
            changed <= 1'b0;
        end else begin
            changed <= upd;
            if (clr) begin
                num <= INIT;
                upd <= 1'b0;
            end else begin
                num <= num_next;
                upd <= any_step;
            end
        end
    end

endmodule

// File: tb/tb_digit_counter_bank.sv
// Directed testbench for digit_counter_bank: step vectors in a table plus
// hand-written bounce, reset and illegal-BCD sequences.
module tb_digit_counter_bank;

    localparam int unsigned D   = 16;
    localparam int unsigned DB  = 4;
    localparam logic [15:0] INIT   = 16'h5703;
    localparam logic [15:0] INIT_B = 16'hA000;

    logic        clk;
    logic        rst;
    logic        rst_b;
    logic [3:0]  sw;
    logic [3:0]  sw_b;
    logic        dir;
    logic        bcd;
    logic        clr;
    logic [15:0] num;
    logic [15:0] num_b;
    logic        changed;
    logic        changed_b;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0]  mask;
        logic        dir;
        logic        bcd;
        logic        clr;
        logic [15:0] exp_num;
        logic        exp_chg;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    digit_counter_bank #(.DIGITS(4), .DEB_CYCLES(D), .INIT(INIT)) dut (
        .clk(clk), .rst(rst), .sw(sw), .dir(dir), .bcd(bcd), .clr(clr),
        .num(num), .changed(changed)
    );

    digit_counter_bank #(.DIGITS(4), .DEB_CYCLES(DB), .INIT(INIT_B)) dut_b (
        .clk(clk), .rst(rst_b), .sw(sw_b), .dir(dir), .bcd(bcd), .clr(clr),
        .num(num_b), .changed(changed_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Hold mask high from the next edge (E0), check exact update edge E0+D+3,
    // the strobe one edge later, then release and check nothing more happens.
    task automatic step_vec(input string name, input logic [3:0] mask,
                            input logic [15:0] exp_old, input logic [15:0] exp_new,
                            input logic exp_chg, input logic clr_upd, input int extra);
        sw = mask;
        repeat (D + 3) tick();
        chk({name, " num before update"}, num, exp_old);
        if (clr_upd) clr = 1'b1;
        tick();
        clr = 1'b0;
        chk({name, " num at update"}, num, exp_new);
        chk({name, " changed at update"}, {15'd0, changed}, 16'd0);
        tick();
        chk({name, " changed after update"}, {15'd0, changed}, {15'd0, exp_chg});
        tick();
        chk({name, " changed drops"}, {15'd0, changed}, 16'd0);
        repeat (extra) tick();
        sw = 4'b0000;
        repeat (D + 6) tick();
        chk({name, " num settled"}, num, exp_new);
    endtask

    logic [15:0] prev;

    initial begin
        vecs[0]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 16'h6825, 1'b1};
        vecs[1]  = '{4'b1111, 1'b0, 1'b0, 1'b1, 16'h5703, 1'b0};
        vecs[2]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 16'h57F3, 1'b1};
        vecs[3]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 16'h5703, 1'b1};
        vecs[4]  = '{4'b0010, 1'b0, 1'b1, 1'b0, 16'h5713, 1'b1};
        vecs[5]  = '{4'b0010, 1'b0, 1'b1, 1'b0, 16'h5723, 1'b1};
        vecs[6]  = '{4'b0010, 1'b0, 1'b1, 1'b0, 16'h5733, 1'b1};
        vecs[7]  = '{4'b0010, 1'b0, 1'b1, 1'b0, 16'h5743, 1'b1};
        vecs[8]  = '{4'b0010, 1'b0, 1'b1, 1'b0, 16'h5753, 1'b1};
        vecs[9]  = '{4'b0010, 1'b0, 1'b1, 1'b0, 16'h5763, 1'b1};
        vecs[10] = '{4'b0010, 1'b0, 1'b1, 1'b0, 16'h5773, 1'b1};
        vecs[11] = '{4'b0010, 1'b0, 1'b1, 1'b0, 16'h5783, 1'b1};
        vecs[12] = '{4'b0010, 1'b0, 1'b1, 1'b0, 16'h5793, 1'b1};
        vecs[13] = '{4'b0010, 1'b0, 1'b1, 1'b0, 16'h5703, 1'b1};
        vecs[14] = '{4'b0010, 1'b1, 1'b1, 1'b0, 16'h5793, 1'b1};
        vecs[15] = '{4'b0010, 1'b0, 1'b0, 1'b0, 16'h57A3, 1'b1};
        vecs[16] = '{4'b0010, 1'b0, 1'b1, 1'b0, 16'h5703, 1'b1};
        vecs[17] = '{4'b0010, 1'b1, 1'b1, 1'b0, 16'h5793, 1'b1};
        vecs[18] = '{4'b0010, 1'b0, 1'b0, 1'b0, 16'h57A3, 1'b1};
        vecs[19] = '{4'b0010, 1'b1, 1'b1, 1'b0, 16'h5793, 1'b1};
        vecs[20] = '{4'b1111, 1'b0, 1'b1, 1'b0, 16'h6804, 1'b1};
        vecs[21] = '{4'b1111, 1'b1, 1'b1, 1'b0, 16'h5793, 1'b1};
        vecs[22] = '{4'b1000, 1'b1, 1'b0, 1'b0, 16'h4793, 1'b1};

        rst = 1'b1; rst_b = 1'b1;
        sw = 4'b0000; sw_b = 4'b0000;
        dir = 1'b0; bcd = 1'b0; clr = 1'b0;
        tick();
        tick();
        chk("reset num", num, INIT);
        chk("reset changed", {15'd0, changed}, 16'd0);
        chk("reset num_b", num_b, INIT_B);
        rst = 1'b0; rst_b = 1'b0;
        tick();

        // Single hex step on digit 0, held well beyond the debounce time.
        step_vec("hex step d0", 4'b0001, 16'h5703, 16'h5704, 1'b1, 1'b0, 25);

        // Bouncy digit 1: short highs never step; timing runs from the final high.
        for (int k = 0; k < 4; k++) begin
            sw = 4'b0010;
            repeat (5) tick();
            sw = 4'b0000;
            repeat (3) tick();
        end
        chk("bounce no step", num, 16'h5704);
        step_vec("bounce final", 4'b0010, 16'h5704, 16'h5714, 1'b1, 1'b0, 10);

        prev = 16'h5714;
        for (int v = 0; v < NV; v++) begin
            dir = vecs[v].dir;
            bcd = vecs[v].bcd;
            step_vec($sformatf("vec%0d", v), vecs[v].mask, prev, vecs[v].exp_num,
                     vecs[v].exp_chg, vecs[v].clr, 0);
            prev = vecs[v].exp_num;
        end

        // Async reset mid-debounce with digit 2 held; one step after release.
        dir = 1'b0; bcd = 1'b0;
        sw = 4'b0100;
        repeat (8) tick();
        rst = 1'b1;
        #1;
        chk("async reset num", num, INIT);
        chk("async reset changed", {15'd0, changed}, 16'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (D + 3) tick();
        chk("post-reset before step", num, 16'h5703);
        tick();
        chk("post-reset step", num, 16'h5803);
        tick();
        chk("post-reset changed", {15'd0, changed}, 16'd1);
        repeat (30) tick();
        chk("post-reset single step", num, 16'h5803);
        sw = 4'b0000;
        repeat (D + 6) tick();

        // Illegal BCD digit from INIT: up goes to 0, down goes to 9.
        bcd = 1'b1; dir = 1'b0;
        sw_b = 4'b1000;
        repeat (DB + 3) tick();
        chk("illegal up before", num_b, 16'hA000);
        tick();
        chk("illegal up", num_b, 16'h0000);
        tick();
        chk("illegal up changed", {15'd0, changed_b}, 16'd1);
        sw_b = 4'b0000;
        repeat (DB + 6) tick();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk("num_b reset again", num_b, 16'hA000);
        dir = 1'b1;
        sw_b = 4'b1000;
        repeat (DB + 4) tick();
        chk("illegal down", num_b, 16'h9000);
        sw_b = 4'b0000;
        repeat (DB + 6) tick();
        chk("main untouched", num, 16'h5803);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
